// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit framer and the
// matching receive deframer.
//   tx_state_t          : framer FSM state encoding
//   parity_mode_t       : runtime parity selection (code 3 behaves as NONE)
//   UART_DATA_BITS_MIN/MAX : legal range of data bits per frame
package uart_pkg;

  localparam int UART_DATA_BITS_MIN = 5;
  localparam int UART_DATA_BITS_MAX = 9;

  typedef enum bit [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_t;

  typedef enum bit [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

endpackage

// File: rtl/uart_tx_framer.sv
// uart_tx_framer -- UART transmit framer between the TX FIFO and the pin.
// Pops a byte from the FIFO and sends start / DATA_BITS data / optional
// parity / one or two stop bits on tx_o, advancing one bit per baud_en_i
// tick. Also generates line breaks on request.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   baud_en_i       : one-cycle bit-period tick (>= 4 clk apart)
//   fifo_empty_i    : FIFO empty flag
//   fifo_rd_data_i  : FIFO read data, valid one cycle after fifo_rd_en_o
//   fifo_rd_en_o    : one-cycle FIFO pop strobe
//   cfg_parity_i    : 0 none, 1 even, 2 odd, 3 none
//   cfg_stop2_i     : 1 selects two stop bits
//   break_i         : hold the line low at the next frame boundary
//   tx_o            : registered serial output, idle high
//   busy_o          : high whenever the FSM is not idle
//   frame_done_o    : one-cycle pulse at the end of a data frame's last stop bit
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en_i,
  input  logic                 fifo_empty_i,
  input  logic [DATA_BITS-1:0] fifo_rd_data_i,
  output logic                 fifo_rd_en_o,
  input  logic [1:0]           cfg_parity_i,
  input  logic                 cfg_stop2_i,
  input  logic                 break_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  generate
    if ((DATA_BITS < UART_DATA_BITS_MIN) || (DATA_BITS > UART_DATA_BITS_MAX)) begin : g_bad_width
      $error("uart_tx_framer: DATA_BITS must be within 5..9");
    end
  endgenerate

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic                 brk_stop_q, brk_stop_d;   // current STOP follows a break
  logic                 rd_en_q, rd_en_d;
  logic                 cap_q, cap_d;             // FIFO data valid this cycle
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 stop_last;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    brk_stop_d = brk_stop_q;
    rd_en_d    = 1'b0;
    cap_d      = rd_en_q;
    done_d     = 1'b0;
    // A stop period after a break is always a single bit.
    stop_last  = brk_stop_q | (stop_cnt_q == stop2_q);

    case (state_q)
      ST_IDLE: begin
        if (baud_en_i) begin
          if (break_i) begin
            state_d = ST_BREAK;
          end else if (!fifo_empty_i) begin
            state_d = ST_START;
            rd_en_d = 1'b1;
          end
        end
      end

      ST_START: begin
        // Data and frame config are frozen together so later config
        // changes cannot corrupt a frame already on the wire.
        if (cap_q) begin
          shift_d   = fifo_rd_data_i;
          par_en_d  = (cfg_parity_i == PAR_EVEN) || (cfg_parity_i == PAR_ODD);
          par_bit_d = (^fifo_rd_data_i) ^ (cfg_parity_i == PAR_ODD);
          stop2_d   = cfg_stop2_i;
        end
        if (baud_en_i) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (baud_en_i) begin
          if (LSB_FIRST) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end else begin
            shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
          end
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
            brk_stop_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (baud_en_i) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          brk_stop_d = 1'b0;
        end
      end

      ST_STOP: begin
        if (baud_en_i) begin
          if (!stop_last) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d     = ~brk_stop_q;
            brk_stop_d = 1'b0;
            if (break_i) begin
              state_d = ST_BREAK;
            end else if (!fifo_empty_i) begin
              state_d = ST_START;
              rd_en_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_BREAK: begin
        if (baud_en_i && !break_i) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          brk_stop_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Line value is decoded from the next state so tx_o moves on the same
    // edge as the state register.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = LSB_FIRST ? shift_d[0] : shift_d[DATA_BITS-1];
      ST_PARITY: tx_d = par_bit_d;
      ST_BREAK:  tx_d = 1'b0;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      brk_stop_q <= 1'b0;
      rd_en_q    <= 1'b0;
      cap_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      brk_stop_q <= brk_stop_d;
      rd_en_q    <= rd_en_d;
      cap_q      <= cap_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx_o         = tx_q;
  assign fifo_rd_en_o = rd_en_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer -- directed bench for uart_tx_framer. One instance is the
// default 8-bit LSB-first framer, a second is a 7-bit MSB-first framer.
// Line samples are taken just after every baud tick; frames are compared as
// packed bit vectors (bit k = k-th bit period, starting at the start bit).
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_en = 1'b0;
  logic [1:0] cfg_parity = 2'd0;
  logic       cfg_stop2 = 1'b0;
  logic       break_in = 1'b0;

  // Main DUT (8 data bits, LSB first)
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en, tx, busy, frame_done;

  // Second DUT (7 data bits, MSB first)
  logic       fifo7_empty = 1'b1;
  logic [6:0] fifo7_rd_data = 7'h00;
  logic       fifo7_rd_en, tx7, busy7, frame_done7;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int rd7_cnt = 0;
  int max_bit_cnt7 = 0;
  int baud_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [6:0] fifo7_q[$];
  bit         line_q[$];
  bit         line7_q[$];

  uart_tx_framer #(.DATA_BITS(8), .LSB_FIRST(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_en_i      (baud_en),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .cfg_parity_i   (cfg_parity),
    .cfg_stop2_i    (cfg_stop2),
    .break_i        (break_in),
    .tx_o           (tx),
    .busy_o         (busy),
    .frame_done_o   (frame_done)
  );

  uart_tx_framer #(.DATA_BITS(7), .LSB_FIRST(1'b0)) dut7 (
    .clk            (clk),
    .rst            (rst),
    .baud_en_i      (baud_en),
    .fifo_empty_i   (fifo7_empty),
    .fifo_rd_data_i (fifo7_rd_data),
    .fifo_rd_en_o   (fifo7_rd_en),
    .cfg_parity_i   (cfg_parity),
    .cfg_stop2_i    (cfg_stop2),
    .break_i        (break_in),
    .tx_o           (tx7),
    .busy_o         (busy7),
    .frame_done_o   (frame_done7)
  );

  always #5 clk = ~clk;

  // One-cycle baud tick every 16 clocks, driven away from the active edge.
  always @(negedge clk) begin
    baud_cnt = (baud_cnt == 15) ? 0 : baud_cnt + 1;
    baud_en  = (baud_cnt == 0);
    fifo_empty  = (fifo_q.size() == 0);
    fifo7_empty = (fifo7_q.size() == 0);
  end

  // FIFO models: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      rd_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  always @(posedge clk) begin
    if (fifo7_rd_en) begin
      if (fifo7_q.size() > 0) fifo7_rd_data <= fifo7_q.pop_front();
      rd7_cnt++;
    end
    if (int'(dut7.bit_cnt_q) > max_bit_cnt7) max_bit_cnt7 = int'(dut7.bit_cnt_q);
  end

  // Line samplers: the value held for each bit period.
  always @(posedge clk) begin
    if (baud_en) begin
      #1;
      line_q.push_back(tx);
      line7_q.push_back(tx7);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s value=%h", tag, got);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!baud_en);
    end
    #2;
  endtask

  task automatic wait_busy(input string tag);
    int i;
    for (i = 0; i < 200 && !busy; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq(tag, {31'd0, busy}, 32'd1);
  endtask

  // Packs n line samples starting at the first start bit after index start.
  task automatic get_bits(input bit sel, input int start, input int n, output logic [31:0] v);
    int first;
    int sz;
    bit b;
    first = -1;
    v = '0;
    sz = sel ? line7_q.size() : line_q.size();
    for (int i = start; i < sz; i++) begin
      b = sel ? line7_q[i] : line_q[i];
      if (!b && first < 0) first = i;
    end
    if (first < 0) begin
      v = 32'hFFFF_FFFF;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (first + k < sz) v[k] = sel ? line7_q[first + k] : line_q[first + k];
        else v[k] = 1'b1;
      end
    end
  endtask

  initial begin
    int idx;
    int rd0;
    int dn0;
    int i;
    logic [31:0] v;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("rst_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    wait_ticks(2);

    // 1: 8N1 with 0x55
    idx = line_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
    fifo_q.push_back(8'h55);
    wait_ticks(14);
    get_bits(1'b0, idx, 12, v);
    check_eq("t1_frame", v, 32'hEAA);
    check_eq("t1_rd_pulses", rd_cnt - rd0, 32'd1);
    check_eq("t1_done_pulses", done_cnt - dn0, 32'd1);
    check_eq("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2a: even parity, 0x07 -> parity bit 1
    cfg_parity = 2'd1;
    idx = line_q.size();
    fifo_q.push_back(8'h07);
    wait_ticks(15);
    get_bits(1'b0, idx, 12, v);
    check_eq("t2_even_frame", v, 32'hE0E);

    // 2b: odd parity, 0x07 -> parity bit 0; config toggled mid-frame
    cfg_parity = 2'd2;
    idx = line_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
    fifo_q.push_back(8'h07);
    wait_busy("t2_odd_busy");
    wait_ticks(3);
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b1;
    wait_ticks(12);
    get_bits(1'b0, idx, 12, v);
    check_eq("t2_odd_frame", v, 32'hC0E);
    check_eq("t2_odd_done", done_cnt - dn0, 32'd1);
    check_eq("t2_odd_rd", rd_cnt - rd0, 32'd1);

    // 3: two stop bits, back-to-back 0xA5, 0x3C
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b1;
    idx = line_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    wait_ticks(28);
    get_bits(1'b0, idx, 24, v);
    check_eq("t3_frames", v, 32'hF3C74A);
    check_eq("t3_rd_pulses", rd_cnt - rd0, 32'd2);
    check_eq("t3_done_pulses", done_cnt - dn0, 32'd2);

    // 5: break requested during DATA of 0xFF
    cfg_stop2 = 1'b0;
    idx = line_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
    fifo_q.push_back(8'hFF);
    wait_busy("t5_busy");
    wait_ticks(3);
    break_in = 1'b1;
    for (i = 0; i < 400 && !frame_done; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("t5_frame_done_seen", {31'd0, frame_done}, 32'd1);
    fifo_q.push_back(8'h81);
    wait_ticks(3);
    check_eq("t5_rd_during_break", rd_cnt - rd0, 32'd1);
    check_eq("t5_tx_break", {31'd0, tx}, 32'd0);
    check_eq("t5_busy_break", {31'd0, busy}, 32'd1);
    break_in = 1'b0;
    wait_ticks(16);
    get_bits(1'b0, idx, 11, v);
    check_eq("t5_frame_then_break", v, 32'h3FE);
    check_eq("t5_rd_end", rd_cnt - rd0, 32'd2);
    check_eq("t5_done_end", done_cnt - dn0, 32'd2);
    check_eq("t5_busy_end", {31'd0, busy}, 32'd0);

    // 6: reset during DATA bit 3, then next byte goes out cleanly
    rd0 = rd_cnt;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h33);
    wait_busy("t6_busy");
    wait_ticks(4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;
    idx = line_q.size();
    wait_ticks(14);
    get_bits(1'b0, idx, 12, v);
    check_eq("t6_next_frame", v, 32'hE66);
    check_eq("t6_rd_total", rd_cnt - rd0, 32'd2);

    // 4: 7 data bits, MSB first, 0x41
    idx = line7_q.size();
    fifo7_q.push_back(7'h41);
    wait_ticks(13);
    get_bits(1'b1, idx, 12, v);
    check_eq("t4_frame7", v, 32'hF82);
    check_eq("t4_rd7", rd7_cnt, 32'd1);
    check_eq("t4_max_bit_cnt", max_bit_cnt7, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
